// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, alignment FSM states and the data-symbol decoder.
// Also intended for reuse by testbench reference models.
package tmds_pkg;

    localparam logic [9:0] TokenC00 = 10'h354;
    localparam logic [9:0] TokenC01 = 10'h0AB;
    localparam logic [9:0] TokenC10 = 10'h154;
    localparam logic [9:0] TokenC11 = 10'h2AB;

    typedef enum logic {
        StSearch,
        StLocked
    } align_state_e;

    function automatic logic is_ctl_token(input logic [9:0] q);
        return (q == TokenC00) || (q == TokenC01) || (q == TokenC10) || (q == TokenC11);
    endfunction

    // Undo DVI 1.0 transition minimisation: q[9] = inverted, q[8] = XOR (1) or XNOR (0) chain.
    function automatic logic [7:0] tmds_decode_data(input logic [9:0] q);
        logic [7:0] t;
        logic [7:0] d;
        t = q[9] ? ~q[7:0] : q[7:0];
        d[0] = t[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = q[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
        end
        return d;
    endfunction

endpackage

// File: rtl/tmds_channel_decoder.sv
// One TMDS lane: 20-bit alignment window, offset search/lock FSM and symbol decode.
// The aligned word is registered (stage 2); decode outputs are combinational from it.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int unsigned LOCK_COUNT     = 8,
    parameter int unsigned SEARCH_TIMEOUT = 2048,
    parameter int unsigned LOSS_TIMEOUT   = 4096
) (
    input  logic       clk_2x,
    input  logic       reset,
    input  logic [9:0] tmds_i,
    output logic [7:0] data_o,
    output logic       ctl_o,
    output logic [1:0] c_o,
    output logic       locked_o
);

    localparam int unsigned MatchW  = $clog2(LOCK_COUNT + 1);
    localparam int unsigned SearchW = $clog2(SEARCH_TIMEOUT);
    localparam int unsigned LossW   = $clog2(LOSS_TIMEOUT);

    logic [9:0]         cur_q, prev_q, aligned_q;
    logic [19:0]        window;
    logic [9:0]         aligned_d;
    align_state_e       state_q, state_d;
    logic [3:0]         offset_q, offset_d, offset_next;
    logic [MatchW-1:0]  match_q, match_d;
    logic [SearchW-1:0] search_q, search_d;
    logic [LossW-1:0]   loss_q, loss_d;
    logic               token;

    // Earlier word sits in the low half so bit order matches arrival order.
    assign window    = {cur_q, prev_q};
    assign aligned_d = window[{1'b0, offset_q} +: 10];

    assign token       = is_ctl_token(aligned_q);
    assign offset_next = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;

    always_ff @(posedge clk_2x) begin
        if (reset) begin
            cur_q     <= '0;
            prev_q    <= '0;
            aligned_q <= '0;
            state_q   <= StSearch;
            offset_q  <= '0;
            match_q   <= '0;
            search_q  <= '0;
            loss_q    <= '0;
        end else begin
            cur_q     <= tmds_i;
            prev_q    <= cur_q;
            aligned_q <= aligned_d;
            state_q   <= state_d;
            offset_q  <= offset_d;
            match_q   <= match_d;
            search_q  <= search_d;
            loss_q    <= loss_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        match_d  = match_q;
        search_d = search_q;
        loss_d   = loss_q;
        case (state_q)
            StSearch: begin
                if (search_q != SearchW'(SEARCH_TIMEOUT - 1)) begin
                    search_d = search_q + SearchW'(1);
                end
                if (!token) begin
                    match_d = '0;
                end else if (match_q != MatchW'(LOCK_COUNT)) begin
                    match_d = match_q + MatchW'(1);
                end
                // Lock takes priority over a simultaneous search timeout.
                if (token && (match_q == MatchW'(LOCK_COUNT - 1))) begin
                    state_d  = StLocked;
                    match_d  = '0;
                    search_d = '0;
                    loss_d   = '0;
                end else if (search_q == SearchW'(SEARCH_TIMEOUT - 1)) begin
                    offset_d = offset_next;
                    match_d  = '0;
                    search_d = '0;
                end
            end
            StLocked: begin
                if (token) begin
                    loss_d = '0;
                end else if (loss_q == LossW'(LOSS_TIMEOUT - 1)) begin
                    state_d  = StSearch;
                    offset_d = offset_next;
                    loss_d   = '0;
                    match_d  = '0;
                    search_d = '0;
                end else begin
                    loss_d = loss_q + LossW'(1);
                end
            end
            default: state_d = StSearch;
        endcase
    end

    always_comb begin
        c_o = 2'b00;
        case (aligned_q)
            TokenC01: c_o = 2'b01;
            TokenC10: c_o = 2'b10;
            TokenC11: c_o = 2'b11;
            default:  c_o = 2'b00;
        endcase
    end

    assign ctl_o    = token;
    assign data_o   = tmds_decode_data(aligned_q);
    assign locked_o = (state_q == StLocked);

endmodule

// File: rtl/tmds_decoder.sv
// Three-lane TMDS receiver: per-lane alignment/decode plus cross-lane enable, sync,
// lock and skew reporting. Fixed 3-cycle latency from raw word to registered outputs.
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int unsigned LOCK_COUNT     = 8,
    parameter int unsigned SEARCH_TIMEOUT = 2048,
    parameter int unsigned LOSS_TIMEOUT   = 4096
) (
    input  logic       clk_2x,
    input  logic       reset,
    input  logic [9:0] tmds_ch0,
    input  logic [9:0] tmds_ch1,
    input  logic [9:0] tmds_ch2,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       vde,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] channel_locked,
    output logic       locked,
    output logic       skew_error
);

    logic [2:0] ctl;
    logic [7:0] ch_data [3];
    logic [1:0] sync_c;
    logic [1:0] unused_c1, unused_c2;

    logic       locked_q;
    logic       vde_q, vde_d;
    logic       skew_q, skew_d;
    logic       hsync_q, hsync_d, vsync_q, vsync_d;
    logic [7:0] red_q, red_d, green_q, green_d, blue_q, blue_d;

    tmds_channel_decoder #(
        .LOCK_COUNT     (LOCK_COUNT),
        .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
        .LOSS_TIMEOUT   (LOSS_TIMEOUT)
    ) u_ch0 (
        .clk_2x   (clk_2x),
        .reset    (reset),
        .tmds_i   (tmds_ch0),
        .data_o   (ch_data[0]),
        .ctl_o    (ctl[0]),
        .c_o      (sync_c),
        .locked_o (channel_locked[0])
    );

    tmds_channel_decoder #(
        .LOCK_COUNT     (LOCK_COUNT),
        .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
        .LOSS_TIMEOUT   (LOSS_TIMEOUT)
    ) u_ch1 (
        .clk_2x   (clk_2x),
        .reset    (reset),
        .tmds_i   (tmds_ch1),
        .data_o   (ch_data[1]),
        .ctl_o    (ctl[1]),
        .c_o      (unused_c1),
        .locked_o (channel_locked[1])
    );

    tmds_channel_decoder #(
        .LOCK_COUNT     (LOCK_COUNT),
        .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
        .LOSS_TIMEOUT   (LOSS_TIMEOUT)
    ) u_ch2 (
        .clk_2x   (clk_2x),
        .reset    (reset),
        .tmds_i   (tmds_ch2),
        .data_o   (ch_data[2]),
        .ctl_o    (ctl[2]),
        .c_o      (unused_c2),
        .locked_o (channel_locked[2])
    );

    always_comb begin
        vde_d   = locked_q & ~(|ctl);
        skew_d  = locked_q & (|ctl) & ~(&ctl);
        blue_d  = vde_d ? ch_data[0] : 8'h00;
        green_d = vde_d ? ch_data[1] : 8'h00;
        red_d   = vde_d ? ch_data[2] : 8'h00;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        // Syncs only ride on lane 0 and are held through active video.
        if (locked_q && ctl[0]) begin
            hsync_d = sync_c[0];
            vsync_d = sync_c[1];
        end
    end

    always_ff @(posedge clk_2x) begin
        if (reset) begin
            locked_q <= 1'b0;
            vde_q    <= 1'b0;
            skew_q   <= 1'b0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
        end else begin
            locked_q <= &channel_locked;
            vde_q    <= vde_d;
            skew_q   <= skew_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
        end
    end

    assign red        = red_q;
    assign green      = green_q;
    assign blue       = blue_q;
    assign vde        = vde_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign locked     = locked_q;
    assign skew_error = skew_q;

endmodule
